// File: rtl/intr_gen.sv
// -----------------------------------------------------------------------------
// intr_gen : APB-programmable interrupt generator
//
// Synchronises NUM_SRC asynchronous sources, latches their rising edges into a
// pending (STATUS) register, masks them with ENABLE, and drives a registered
// level IRQ. Software services it over a zero-wait-state APB slave.
//
// Register map (word offsets, decoded on PADDR[3:2]):
//   0x0 STATUS  RO pending bits, write-1-to-clear
//   0x4 ENABLE  RW per-source enable (gates IRQ only)
//   0x8 RAW     RO synchronised source levels
//   0xC CTRL    bit0 GIE, bit1 FORCE (FORCE only when FORCE_EN != 0)
//
// Ports:
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   PSEL..PWDATA         APB slave inputs
//   PRDATA               read data, combinational in the read access phase
//   PREADY, PSLVERR      tied 1 / tied 0
//   src                  asynchronous rising-edge-sensitive sources
//   IRQ                  registered level interrupt
// -----------------------------------------------------------------------------
module intr_gen #(
    parameter int NUM_SRC  = 8,
    parameter int FORCE_EN = 1
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [3:0]         PADDR,
    input  logic [31:0]        PWDATA,
    output logic [31:0]        PRDATA,
    output logic               PREADY,
    output logic               PSLVERR,
    input  logic [NUM_SRC-1:0] src,
    output logic               IRQ
);

    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_status;
    logic [NUM_SRC-1:0] r_enable;
    logic               r_gie;
    logic               r_force;
    logic               r_irq;

    logic               w_wr;
    logic               w_rd;
    logic               w_sel_status;
    logic               w_sel_enable;
    logic               w_sel_ctrl;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_clr;
    logic               w_unused_apb;

    assign w_wr         = PSEL & PENABLE & PWRITE;
    assign w_rd         = PSEL & PENABLE & ~PWRITE;
    assign w_sel_status = (PADDR[3:2] == 2'd0);
    assign w_sel_enable = (PADDR[3:2] == 2'd1);
    assign w_sel_ctrl   = (PADDR[3:2] == 2'd3);

    assign w_rise = r_sync2 & ~r_prev;
    assign w_clr  = (w_wr && w_sel_status) ? PWDATA[NUM_SRC-1:0] : '0;

    // Byte-lane bits and data bits beyond the implemented width are don't-care.
    assign w_unused_apb = ^{PADDR[1:0], PWDATA};

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_status <= '0;
            r_enable <= '0;
            r_gie    <= 1'b0;
            r_force  <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_sync1 <= src;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;

            // Clear is applied before set so a coincident rise keeps the bit.
            r_status <= (r_status & ~w_clr) | w_rise;

            if (w_wr && w_sel_enable) begin
                r_enable <= PWDATA[NUM_SRC-1:0];
            end

            if (w_wr && w_sel_ctrl) begin
                r_gie   <= PWDATA[0];
                r_force <= (FORCE_EN != 0) ? PWDATA[1] : 1'b0;
            end

            // Built from pre-edge register state, so IRQ trails it by one clock.
            r_irq <= (r_gie & (|(r_status & r_enable))) | r_force;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (w_rd) begin
            case (PADDR[3:2])
                2'd0:    PRDATA[NUM_SRC-1:0] = r_status;
                2'd1:    PRDATA[NUM_SRC-1:0] = r_enable;
                2'd2:    PRDATA[NUM_SRC-1:0] = r_sync2;
                default: PRDATA[1:0]         = {r_force, r_gie};
            endcase
        end
    end

    assign IRQ     = r_irq;
    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

endmodule

// File: tb/tb_intr_gen.sv
module tb_intr_gen;

    localparam int N = 8;

    logic        clk;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [N-1:0] src;
    logic        irq;

    int n_pass;
    int n_total;

    intr_gen #(.NUM_SRC(N), .FORCE_EN(1)) dut (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata),
        .PREADY(pready), .PSLVERR(pslverr), .src(src), .IRQ(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Source value sampled at each edge is recorded by edge index; a pending
    // bit sets at edge k when src was high at edge k-2 and low at edge k-3.
    int           cyc;
    logic [N-1:0] srch [0:3];
    logic [N-1:0] m_status, m_enable;
    logic         m_gie, m_force, m_irq;

    function automatic logic [N-1:0] hs(input int n);
        if (n < 0) return '0;
        return srch[n % 4];
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [31:0] v;
        v = 32'd0;
        case (a[3:2])
            2'd0: v[N-1:0] = m_status;
            2'd1: v[N-1:0] = m_enable;
            2'd2: v[N-1:0] = hs(cyc - 1);
            default: v[1:0] = {m_force, m_gie};
        endcase
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic         irq_next;
        logic         wr;
        logic [N-1:0] clr;
        logic [N-1:0] rise;
        if (!rst_n) begin
            cyc      = -1;
            m_status = '0;
            m_enable = '0;
            m_gie    = 1'b0;
            m_force  = 1'b0;
            m_irq    = 1'b0;
        end else begin
            cyc = cyc + 1;
            srch[cyc % 4] = src;
            irq_next = (m_gie && ((m_status & m_enable) != '0)) || m_force;
            wr   = psel && penable && pwrite;
            clr  = (wr && paddr[3:2] == 2'd0) ? pwdata[N-1:0] : '0;
            rise = hs(cyc - 2) & ~hs(cyc - 3);
            m_status = (m_status & ~clr) | rise;
            if (wr && paddr[3:2] == 2'd1) m_enable = pwdata[N-1:0];
            if (wr && paddr[3:2] == 2'd3) begin
                m_gie   = pwdata[0];
                m_force = pwdata[1];
            end
            m_irq = irq_next;
        end
    end

    // ---------------- APB drivers ----------------
    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Returns the observed read data and the model's value at the same instant.
    task automatic apb_read(input logic [3:0] a, output logic [31:0] d,
                            output logic [31:0] e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1;
        d = prdata;
        e = model_read(a);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic do_reset();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0; pwdata = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d, e;
        src = '0;
        do_reset();
        @(negedge clk);
        n_total++;
        if (irq !== 1'b0) $display("FAIL reset_irq got=%0b want=0", irq); else n_pass++;
        n_total++;
        if (prdata !== 32'h0) $display("FAIL reset_prdata got=%h want=0", prdata); else n_pass++;
        for (int a = 0; a < 4; a++) begin
            apb_read(4'(a * 4), d, e);
            n_total++;
            if (d !== 32'h0) $display("FAIL reset_reg%0d got=%h want=0", a, d); else n_pass++;
        end
    endtask

    task automatic test_latency();
        logic [31:0] d, e;
        apb_write(4'h4, 32'h01);
        apb_write(4'hC, 32'h01);
        @(negedge clk); src[0] = 1'b1;            // edge N follows
        @(negedge clk);                           // after N
        n_total++;
        if (irq !== 1'b0) $display("FAIL lat_irq_n got=%0b want=0", irq); else n_pass++;
        @(negedge clk);                           // after N+1
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0;
        n_total++;
        if (irq !== 1'b0) $display("FAIL lat_irq_n1 got=%0b want=0", irq); else n_pass++;
        @(negedge clk);                           // after N+2
        penable = 1'b1;
        #1;
        n_total++;
        if (prdata !== 32'h01) $display("FAIL lat_status_n2 got=%h want=01", prdata); else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL lat_irq_n2 got=%0b want=0", irq); else n_pass++;
        @(negedge clk);                           // after N+3
        psel = 1'b0; penable = 1'b0;
        n_total++;
        if (irq !== 1'b1) $display("FAIL lat_irq_n3 got=%0b want=1", irq); else n_pass++;
        repeat (20) @(negedge clk);
        apb_read(4'h0, d, e);
        n_total++;
        if (d !== 32'h01 || d !== e) $display("FAIL lat_hold_status got=%h want=01 model=%h", d, e); else n_pass++;
        apb_read(4'h8, d, e);
        n_total++;
        if (d !== 32'h01) $display("FAIL lat_raw got=%h want=01", d); else n_pass++;
        src = '0;
        apb_write(4'h0, 32'hFF);
    endtask

    task automatic test_masked();
        logic [31:0] d, e;
        apb_write(4'h4, 32'h00);
        @(negedge clk); src[3] = 1'b1;
        repeat (4) @(negedge clk);
        src[3] = 1'b0;
        repeat (4) @(negedge clk);
        apb_read(4'h0, d, e);
        n_total++;
        if (d !== 32'h08) $display("FAIL mask_status got=%h want=08", d); else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL mask_irq got=%0b want=0", irq); else n_pass++;
        apb_write(4'h4, 32'h08);                  // returns just after access edge M
        n_total++;
        if (irq !== 1'b0) $display("FAIL mask_irq_m got=%0b want=0", irq); else n_pass++;
        @(negedge clk);
        n_total++;
        if (irq !== 1'b1) $display("FAIL mask_irq_m1 got=%0b want=1", irq); else n_pass++;
        apb_write(4'h0, 32'hFF);
    endtask

    task automatic test_w1c();
        logic [31:0] d, e;
        apb_write(4'h4, 32'h05);
        @(negedge clk); src = 8'h05;
        repeat (3) @(negedge clk);
        src = '0;
        repeat (4) @(negedge clk);
        apb_read(4'h0, d, e);
        n_total++;
        if (d !== 32'h05) $display("FAIL w1c_pre got=%h want=05", d); else n_pass++;
        apb_write(4'h0, 32'h04);
        apb_read(4'h0, d, e);
        n_total++;
        if (d !== 32'h01) $display("FAIL w1c_bit2 got=%h want=01", d); else n_pass++;
        n_total++;
        if (irq !== 1'b1) $display("FAIL w1c_irq_hold got=%0b want=1", irq); else n_pass++;
        apb_write(4'h0, 32'h01);
        n_total++;
        if (irq !== 1'b1) $display("FAIL w1c_irq_m got=%0b want=1", irq); else n_pass++;
        @(negedge clk);
        n_total++;
        if (irq !== 1'b0) $display("FAIL w1c_irq_m1 got=%0b want=0", irq); else n_pass++;
        apb_read(4'h0, d, e);
        n_total++;
        if (d !== 32'h00) $display("FAIL w1c_empty got=%h want=00", d); else n_pass++;
    endtask

    task automatic test_collision();
        logic [31:0] d, e;
        apb_write(4'h4, 32'h04);
        @(negedge clk); src[2] = 1'b1;
        repeat (3) @(negedge clk);
        src[2] = 1'b0;
        repeat (4) @(negedge clk);
        @(negedge clk); src[2] = 1'b1;            // edge N follows; rise at N+2
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h0; pwdata = 32'h04;
        @(negedge clk);
        penable = 1'b1;                           // access edge is N+2
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        n_total++;
        if (irq !== 1'b1) $display("FAIL coll_irq_m got=%0b want=1", irq); else n_pass++;
        @(negedge clk);
        n_total++;
        if (irq !== 1'b1) $display("FAIL coll_irq_m1 got=%0b want=1", irq); else n_pass++;
        apb_read(4'h0, d, e);
        n_total++;
        if (d !== 32'h04) $display("FAIL coll_status got=%h want=04", d); else n_pass++;
        src = '0;
    endtask

    task automatic test_gie_force();
        logic [31:0] d, e;
        apb_write(4'hC, 32'h00);
        @(negedge clk);
        n_total++;
        if (irq !== 1'b0) $display("FAIL gie_off_irq got=%0b want=0", irq); else n_pass++;
        apb_write(4'h0, 32'hFF);
        apb_write(4'hC, 32'h02);
        @(negedge clk);
        n_total++;
        if (irq !== 1'b1) $display("FAIL force_irq got=%0b want=1", irq); else n_pass++;
        apb_read(4'h0, d, e);
        n_total++;
        if (d !== 32'h00) $display("FAIL force_status got=%h want=00", d); else n_pass++;
        apb_read(4'hC, d, e);
        n_total++;
        if (d !== 32'h02) $display("FAIL force_ctrl got=%h want=02", d); else n_pass++;
        apb_write(4'hC, 32'h03);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'hC;
        @(negedge clk);
        penable = 1'b1;
        #1;
        n_total++;
        if (prdata !== 32'h03) $display("FAIL rst_pre_prdata got=%h want=03", prdata); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (irq !== 1'b0) $display("FAIL rst_async_irq got=%0b want=0", irq); else n_pass++;
        n_total++;
        if (prdata !== 32'h0) $display("FAIL rst_async_prdata got=%h want=0", prdata); else n_pass++;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            apb_read(4'(a * 4), d, e);
            n_total++;
            if (d !== 32'h0) $display("FAIL rst_after_reg%0d got=%h want=0", a, d); else n_pass++;
        end
        n_total++;
        if (irq !== 1'b0) $display("FAIL rst_after_irq got=%0b want=0", irq); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] d, e, wd;
        logic [3:0]  a;
        int          op;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_total++;
            if (irq !== m_irq) $display("FAIL rand_irq i=%0d got=%0b want=%0b", i, irq, m_irq); else n_pass++;
            if ($urandom_range(0, 3) == 0) src = N'($urandom);
            op = int'($urandom_range(0, 5));
            a  = {2'($urandom_range(0, 3)), 2'b00};
            if (op == 0) begin
                wd = $urandom;
                if (a == 4'hC) wd = {30'd0, ($urandom_range(0, 5) == 0), 1'($urandom)};
                apb_write(a, wd);
            end else if (op == 1) begin
                apb_read(a, d, e);
                n_total++;
                if (d !== e) $display("FAIL rand_read i=%0d addr=%h got=%h want=%h", i, a, d, e); else n_pass++;
            end
        end
        n_total++;
        if (pready !== 1'b1 || pslverr !== 1'b0)
            $display("FAIL tie_offs got=%0b%0b want=10", pready, pslverr);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        src     = '0;
        rst_n   = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0; pwdata = 32'h0;
        test_reset();
        test_latency();
        test_masked();
        test_w1c();
        test_collision();
        test_gie_force();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
